// File: rtl/display_pkg.sv
// display_pkg: shared seven-segment display constants and the digit slice helper.
package display_pkg;
    localparam int NUM_DIGITS = 6;
    localparam int SEG_W = 8;
    localparam int DW = $clog2(NUM_DIGITS);
    localparam logic [SEG_W-1:0] SEG_OFF = 8'hFF;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = 6'b111111;

    function automatic logic [SEG_W-1:0] digit_slice(input logic [NUM_DIGITS*SEG_W-1:0] bus, input logic [DW-1:0] d);
        return bus[d*SEG_W +: SEG_W];
    endfunction
endpackage

// File: rtl/scan_timer.sv
// scan_timer: slot/digit/frame counters and blink phase for the display scan.
module scan_timer
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int GUARD = 16,
    parameter int BLINK_FRAMES = 83
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [DW-1:0] d,
    output logic          active,
    output logic          frame_end,
    output logic          blink_phase
);
    localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [DW-1:0] D_LAST = DW'(NUM_DIGITS - 1);

    logic [CW-1:0] c;
    logic [FW-1:0] f;
    logic slot_end;

    assign slot_end = c == C_LAST;
    assign frame_end = slot_end && d == D_LAST;
    assign active = c >= CW'(GUARD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c <= '0;
            d <= '0;
            f <= '0;
            blink_phase <= 1'b0;
        end else begin
            c <= slot_end ? '0 : c + 1'b1;
            if (slot_end)
                d <= frame_end ? '0 : d + 1'b1;
            if (frame_end) begin
                f <= f == F_LAST ? '0 : f + 1'b1;
                if (f == F_LAST)
                    blink_phase <= ~blink_phase;
            end
        end
    end
endmodule

// File: rtl/display_scan.sv
// display_scan: time-multiplexed 6-digit common-anode driver with frame-latched
// segment bus, anti-ghosting guard time and per-digit blinking.
module display_scan
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int GUARD = 16,
    parameter int BLINK_FRAMES = 83
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]       blk,
    input  logic                        norm,
    output logic [NUM_DIGITS-1:0]       an,
    output logic [SEG_W-1:0]            seg
);
    logic [DW-1:0] d;
    logic active, frame_end, blink_phase, visible;
    logic [NUM_DIGITS*SEG_W-1:0] shadow_seg;
    logic [NUM_DIGITS-1:0] shadow_blk;

    scan_timer #(
        .SCAN_DIV(SCAN_DIV),
        .GUARD(GUARD),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_timer (
        .clk(clk),
        .rst_n(rst_n),
        .d(d),
        .active(active),
        .frame_end(frame_end),
        .blink_phase(blink_phase)
    );

    assign visible = active && !(blink_phase && shadow_blk[d]);

    // Shadows load only at frame end so a frame is never torn by input changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an <= AN_OFF;
            seg <= SEG_OFF;
            shadow_seg <= '0;
            shadow_blk <= '0;
        end else begin
            an <= visible ? ~(NUM_DIGITS'(1) << d) : AN_OFF;
            seg <= visible ? ~digit_slice(shadow_seg, d) : SEG_OFF;
            if (frame_end) begin
                shadow_seg <= seg_in;
                shadow_blk <= blk | {NUM_DIGITS{~norm}};
            end
        end
    end
endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: scoreboard bench; a frame-level model predicts every output cycle.
module tb_display_scan;
    import display_pkg::*;
    localparam int SD = 8;
    localparam int G = 2;
    localparam int BF = 2;
    localparam int FR = NUM_DIGITS * SD;
    localparam logic [47:0] PATTERN = 48'h6D_66_4F_5B_06_3F;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [47:0] seg_in = '0;
    logic [5:0] blk = '0;
    logic norm = 1'b1;
    logic [5:0] an;
    logic [7:0] seg;

    int checks = 0;
    int errors = 0;
    int t = 0;
    logic [13:0] exp_q[$];
    logic [47:0] sh_seg[0:255];
    logic [5:0] sh_blk[0:255];

    display_scan #(.SCAN_DIV(SD), .GUARD(G), .BLINK_FRAMES(BF)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .seg_in(seg_in),
        .blk(blk),
        .norm(norm),
        .an(an),
        .seg(seg)
    );

    always #5 clk = ~clk;

    // Output at cycle t reflects the scan position of cycle t-1; frame n shows
    // what was on the inputs at the last cycle of frame n-1 (frame 0 is blank).
    function automatic logic [13:0] model(input int tc);
        int s, n, d, c;
        logic vis;
        if (tc == 0) return {AN_OFF, SEG_OFF};
        s = tc - 1;
        n = s / FR;
        d = (s / SD) % NUM_DIGITS;
        c = s % SD;
        vis = (c >= G) && !(((n / BF) % 2 == 1) && sh_blk[n][d]);
        return vis ? {~(6'd1 << d), ~sh_seg[n][8*d +: 8]} : {AN_OFF, SEG_OFF};
    endfunction

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d: got an=%b seg=%h, expected an=%b seg=%h",
                     name, t, got[13:8], got[7:0], exp[13:8], exp[7:0]);
        end
    endtask

    task automatic run_cycles(input int n, input bit rnd);
        repeat (n) begin
            exp_q.push_back(model(t));
            if (rnd) begin
                if ($urandom_range(15) == 0) seg_in = 48'({$urandom, $urandom});
                if ($urandom_range(31) == 0) blk = 6'($urandom);
                if ($urandom_range(63) == 0) norm = ~norm;
            end
            if (t % FR == FR - 1) begin
                sh_seg[t / FR + 1] = seg_in;
                sh_blk[t / FR + 1] = blk | {6{~norm}};
            end
            t++;
            @(negedge clk);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        sh_seg[0] = '0;
        sh_blk[0] = '0;
    endtask

    initial forever begin
        @(negedge clk);
        #1;
        if (exp_q.size() > 0) check("scan", {an, seg}, exp_q.pop_front());
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("reset", {an, seg}, {AN_OFF, SEG_OFF});
        end
        release_reset();
        run_cycles(40, 0);
        seg_in = PATTERN;
        run_cycles(20, 0);
        seg_in = 48'h7F7F7F7F7F7F;
        run_cycles(50, 0);
        blk = 6'b000100;
        run_cycles(4 * FR, 0);
        blk = '0;
        norm = 1'b0;
        run_cycles(3 * FR + 20, 0);
        norm = 1'b1;
        run_cycles(2 * FR, 0);
        run_cycles(1500, 1);

        // Park on a visible digit 3 slot, then pull reset between clock edges.
        norm = 1'b1;
        blk = '0;
        seg_in = PATTERN;
        run_cycles((31 - t % FR + FR) % FR + FR, 0);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {an, seg}, {AN_OFF, SEG_OFF});
        repeat (3) begin
            @(negedge clk);
            check("reset_hold", {an, seg}, {AN_OFF, SEG_OFF});
        end
        release_reset();
        run_cycles(3 * FR, 0);
        run_cycles(500, 1);

        @(negedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
